// File: rtl/gf180mcu_osu_sc_12t_cellchk.sv
// Exhaustive stimulus generator / response checker for one combinational library cell.
// Optional MISR signature output enabled by defining GF180MCU_OSU_SC_CELLCHK_MISR_EN.
module gf180mcu_osu_sc_12t_cellchk #(
  parameter int                  NIN    = 2,
  parameter logic [(2**NIN)-1:0] TT     = 4'b0001,
  parameter int                  SETTLE = 2
) (
  input  logic           CLK,
  input  logic           RN,
  input  logic           START,
  input  logic           Y_DUT,
  output logic [NIN-1:0] STIM,
  output logic           BUSY,
  output logic           DONE,
  output logic           PASS,
  output logic [7:0]     ERR_CNT,
  output logic           FAIL_VLD,
  output logic [NIN-1:0] FAIL_VEC
`ifdef GF180MCU_OSU_SC_CELLCHK_MISR_EN
  ,
  output logic [15:0]    SIG
`endif
);

  // START is a level request with no handshake: it is accepted on any rising
  // edge where the checker is IDLE and START=1, and ignored while in RUN.
  // BUSY is a direct decode of the state register (BUSY=1 <=> RUN).

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [NIN-1:0] LAST_VEC = '1;
  localparam logic [7:0]     SETTLE_L = 8'(SETTLE);

  state_t         state_q, state_d;
  logic [NIN-1:0] vec_q, vec_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           fail_vld_q, fail_vld_d;
  logic [NIN-1:0] fail_vec_q, fail_vec_d;

  logic sample;
  logic mismatch;
  logic accept;

  assign accept   = (state_q == S_IDLE) && START;
  assign sample   = (state_q == S_RUN) && (cnt_q <= 8'd1);
  assign mismatch = (Y_DUT != TT[vec_q]);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    fail_vld_d = fail_vld_q;
    fail_vec_d = fail_vec_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d    = S_RUN;
          vec_d      = '0;
          cnt_d      = SETTLE_L;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_cnt_d  = 8'd0;
          fail_vld_d = 1'b0;
          fail_vec_d = '0;
        end
      end
      S_RUN: begin
        if (!sample) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          if (mismatch) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (!fail_vld_q) begin
              fail_vld_d = 1'b1;
              fail_vec_d = vec_q;
            end
          end
          if (vec_q == LAST_VEC) begin
            // Last vector: finish, park STIM at zero and publish the verdict.
            state_d = S_IDLE;
            vec_d   = '0;
            done_d  = 1'b1;
            pass_d  = !fail_vld_q && !mismatch;
          end else begin
            vec_d = vec_q + 1'b1;
            cnt_d = SETTLE_L;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      cnt_q      <= 8'd0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 8'd0;
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fail_vld_q <= fail_vld_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign STIM     = vec_q;
  assign BUSY     = (state_q == S_RUN);
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_cnt_q;
  assign FAIL_VLD = fail_vld_q;
  assign FAIL_VEC = fail_vec_q;

`ifdef GF180MCU_OSU_SC_CELLCHK_MISR_EN
  logic [15:0] sig_q, sig_d;

  // CRC-CCITT style serial MISR over the raw sampled response sequence.
  always_comb begin
    sig_d = sig_q;
    if (accept) begin
      sig_d = 16'hFFFF;
    end else if (sample) begin
      sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ Y_DUT) ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) sig_q <= 16'hFFFF;
    else     sig_q <= sig_d;
  end

  assign SIG = sig_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
